kim_muldiv_ctrl_p: RTL

//  Iterative multiply/divide sequencer for the EX stage of the 32-bit pipelined MIPS core. Executes MULT/MULTU/DIV/DIVU
//  one bit per cycle on a shared shift/add-sub datapath and writes the HI/LO result registers.

---
 rtl/kim_muldiv_ctrl_p.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/kim_muldiv_ctrl_p.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage. Produces one bit per cycle on a shared
// shift/add-sub datapath, then applies sign correction and commits HI/LO.
module kim_muldiv_ctrl_p #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic [1:0]            op_in,
    input  logic [DATA_WIDTH-1:0] src_a_in,
    input  logic [DATA_WIDTH-1:0] src_b_in,
    input  logic                  flush_in,
    output logic                  busy,
    output logic                  done,
    output logic                  stall_req,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int DW = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*DW-1:0] cond_neg2(input logic [2*DW-1:0] v, input logic neg);
        return neg ? (~v + {{(2*DW-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t               state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [DW-1:0]        opnd_r;
    logic [DW-1:0]        work_hi_r;
    logic [DW-1:0]        work_lo_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic                 is_div_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 div_zero_r;
    logic [DW-1:0]        hi_r;
    logic [DW-1:0]        lo_r;

    logic [DW-1:0]        mag_a_s;
    logic [DW-1:0]        mag_b_s;
    logic [DW:0]          mul_sum_s;
    logic [DW:0]          div_shift_s;
    logic                 div_ge_s;
    logic [DW-1:0]        rem_sub_s;
    logic [2*DW-1:0]      prod_fix_s;
    logic [DW-1:0]        quo_fix_s;
    logic [DW-1:0]        rem_fix_s;

    // Operand magnitudes, one iteration step of each algorithm, and sign-corrected results
    always_comb begin
        mag_a_s     = cond_neg(src_a_in, op_in[0] & src_a_in[DW-1]);
        mag_b_s     = cond_neg(src_b_in, op_in[0] & src_b_in[DW-1]);
        mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(DW+1){1'b0}});
        div_shift_s = {work_hi_r, work_lo_r[DW-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        rem_sub_s   = div_shift_s[DW-1:0] - opnd_r;
        prod_fix_s  = cond_neg2({work_hi_r, work_lo_r}, neg_res_r);
        quo_fix_s   = cond_neg(work_lo_r, neg_res_r);
        rem_fix_s   = cond_neg(work_hi_r, neg_rem_r);
    end

    // Sequencer FSM with registered status outputs and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            opnd_r     <= {DW{1'b0}};
            work_hi_r  <= {DW{1'b0}};
            work_lo_r  <= {DW{1'b0}};
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            is_div_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {DW{1'b0}};
            lo_r       <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_in && !flush_in) begin
                        cnt_r      <= {CNT_WIDTH{1'b0}};
                        div_zero_r <= 1'b0;
                        is_div_r   <= op_in[1];
                        neg_res_r  <= op_in[0] & (src_a_in[DW-1] ^ src_b_in[DW-1]);
                        neg_rem_r  <= op_in[0] & src_a_in[DW-1];
                        work_hi_r  <= {DW{1'b0}};
                        opnd_r     <= op_in[1] ? mag_b_s : mag_a_s;
                        work_lo_r  <= op_in[1] ? mag_a_s : mag_b_s;
                        if (!op_in[1]) begin
                            state_r <= ST_MUL;
                            busy_r  <= 1'b1;
                        end else if (src_b_in == {DW{1'b0}}) begin
                            // Divide by zero commits immediately without iterating
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                            hi_r       <= src_a_in;
                            lo_r       <= {DW{1'b1}};
                        end else begin
                            state_r <= ST_DIV;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush_in) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        {work_hi_r, work_lo_r} <= {mul_sum_s, work_lo_r[DW-1:1]};
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) state_r <= ST_FIX;
                    end
                end
                ST_DIV: begin
                    if (flush_in) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        work_hi_r <= div_ge_s ? rem_sub_s : div_shift_s[DW-1:0];
                        work_lo_r <= {work_lo_r[DW-2:0], div_ge_s};
                        cnt_r     <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    busy_r <= 1'b0;
                    if (flush_in) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        if (is_div_r) begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end else begin
                            {hi_r, lo_r} <= prod_fix_s;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign div_zero  = div_zero_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign stall_req = (start_in & (state_r == ST_IDLE) & ~flush_in) | busy_r;

endmodule
